// File: rtl/queue_rf_mc_if.sv
// queue_rf_mc_if: push/pop ports and per-channel status of queue_rf_mc.
// QUEUE_RF_MC_ERR_EN adds sticky overflow/underflow flags and their clear.
interface queue_rf_mc_if #(parameter int N = 4, parameter int W = 32, parameter int C = 4);
  localparam int A = $clog2(N);
  localparam int CW = $clog2(C);
  logic i_push;
  logic [CW-1:0] i_push_ch;
  logic [W-1:0] i_push_dat;
  logic i_pop;
  logic [CW-1:0] i_pop_ch;
  logic [W-1:0] o_pop_dat;
  logic [C-1:0] o_full_w;
  logic [C-1:0] o_empty_w;
  logic [C*(A+1)-1:0] o_cnt_w;
`ifdef QUEUE_RF_MC_ERR_EN
  logic [C-1:0] o_ovf_err;
  logic [C-1:0] o_udf_err;
  logic i_err_clr;
  modport master(output i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch, i_err_clr,
                 input o_pop_dat, o_full_w, o_empty_w, o_cnt_w, o_ovf_err, o_udf_err);
  modport slave(input i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch, i_err_clr,
                output o_pop_dat, o_full_w, o_empty_w, o_cnt_w, o_ovf_err, o_udf_err);
`else
  modport master(output i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch,
                 input o_pop_dat, o_full_w, o_empty_w, o_cnt_w);
  modport slave(input i_push, i_push_ch, i_push_dat, i_pop, i_pop_ch,
                output o_pop_dat, o_full_w, o_empty_w, o_cnt_w);
`endif
endinterface

// File: rtl/queue_rf_mc.sv
// queue_rf_mc: C independent N-deep FIFOs statically partitioned in one shared register file.
// Optional QUEUE_RF_MC_ERR_EN adds sticky per-channel overflow/underflow error flags.
module queue_rf_mc #(
  parameter int N = 4,
  parameter int W = 32,
  parameter int C = 4,
  parameter int FLOP_OUT = 0
) (
  input logic clk,
  input logic rst,
  queue_rf_mc_if.slave q
);
  localparam int A = $clog2(N);
  localparam int CW = $clog2(C);
  localparam logic [A:0] FULL = (A+1)'(N);
  if (FLOP_OUT != 0) begin : g_flop_out_chk
    $error("queue_rf_mc: FLOP_OUT is not supported and must be 0");
  end
  logic [W-1:0] rf [C*N];
  logic [A-1:0] rd_ptr [C];
  logic [A-1:0] wr_ptr [C];
  logic [A:0] cnt [C];
  logic pop_ok, push_ok;
  logic [C-1:0] push_hit, pop_hit;
  // a full channel still takes a push when the same cycle pops it
  always_comb begin
    pop_ok = q.i_pop & (cnt[q.i_pop_ch] != '0);
    push_ok = q.i_push & ((cnt[q.i_push_ch] != FULL) | (pop_ok & (q.i_push_ch == q.i_pop_ch)));
    push_hit = '0;
    pop_hit = '0;
    for (int c = 0; c < C; c++) begin
      push_hit[c] = push_ok & (q.i_push_ch == CW'(c));
      pop_hit[c] = pop_ok & (q.i_pop_ch == CW'(c));
    end
  end
  always_ff @(posedge clk)
    if (push_ok & ~rst) rf[{q.i_push_ch, wr_ptr[q.i_push_ch]}] <= q.i_push_dat;
  always_ff @(posedge clk) begin
    for (int c = 0; c < C; c++) begin
      if (rst) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c] <= '0;
      end else begin
        if (push_hit[c]) wr_ptr[c] <= wr_ptr[c] + A'(1);
        if (pop_hit[c]) rd_ptr[c] <= rd_ptr[c] + A'(1);
        cnt[c] <= cnt[c] + (A+1)'(push_hit[c]) - (A+1)'(pop_hit[c]);
      end
    end
  end
  always_comb begin
    q.o_pop_dat = rf[{q.i_pop_ch, rd_ptr[q.i_pop_ch]}];
    q.o_full_w = '0;
    q.o_empty_w = '0;
    q.o_cnt_w = '0;
    for (int c = 0; c < C; c++) begin
      q.o_full_w[c] = cnt[c] == FULL;
      q.o_empty_w[c] = cnt[c] == '0;
      q.o_cnt_w[c*(A+1) +: A+1] = cnt[c];
    end
  end
`ifdef QUEUE_RF_MC_ERR_EN
  logic [C-1:0] ovf_err, udf_err, ovf_set, udf_set;
  always_comb begin
    ovf_set = '0;
    udf_set = '0;
    for (int c = 0; c < C; c++) begin
      ovf_set[c] = q.i_push & ~push_ok & (q.i_push_ch == CW'(c));
      udf_set[c] = q.i_pop & ~pop_ok & (q.i_pop_ch == CW'(c));
    end
  end
  // a new error in the clearing cycle survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= '0;
      udf_err <= '0;
    end else begin
      ovf_err <= (q.i_err_clr ? '0 : ovf_err) | ovf_set;
      udf_err <= (q.i_err_clr ? '0 : udf_err) | udf_set;
    end
  end
  assign q.o_ovf_err = ovf_err;
  assign q.o_udf_err = udf_err;
`endif
endmodule

// File: tb/tb_queue_rf_mc.sv
// tb_queue_rf_mc: directed scoreboard bench; stimulus queues expected pop data, a negedge monitor checks it.
module tb_queue_rf_mc;
  localparam int N = 4, W = 32, C = 4, A = 2;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  queue_rf_mc_if #(.N(N), .W(W), .C(C)) q();
  queue_rf_mc #(.N(N), .W(W), .C(C), .FLOP_OUT(0)) dut(.clk(clk), .rst(rst), .q(q.slave));
  int errors = 0;
  int checks = 0;
  int mc [C];
  logic [W-1:0] exp_q [$];
  logic [W-1:0] r [4];
  logic [W-1:0] rr [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic status(input string tag);
    logic [C-1:0] f, e;
    logic [C*(A+1)-1:0] cv;
    for (int c = 0; c < C; c++) begin
      f[c] = mc[c] == N;
      e[c] = mc[c] == 0;
      cv[c*(A+1) +: A+1] = (A+1)'(mc[c]);
    end
    chk({tag, "_full"}, 64'(q.o_full_w), 64'(f));
    chk({tag, "_empty"}, 64'(q.o_empty_w), 64'(e));
    chk({tag, "_cnt"}, 64'(q.o_cnt_w), 64'(cv));
  endtask

  task automatic cyc(input logic pu, input int pch, input logic [W-1:0] pd,
                     input logic po, input int och, input logic [W-1:0] ex);
    bit pok, uok;
    q.i_push = pu;
    q.i_push_ch = 2'(pch);
    q.i_push_dat = pd;
    q.i_pop = po;
    q.i_pop_ch = 2'(och);
    pok = po && mc[och] > 0;
    uok = pu && (mc[pch] < N || (pok && och == pch));
    if (pok) exp_q.push_back(ex);
    @(posedge clk);
    #1;
    if (pok) mc[och]--;
    if (uok) mc[pch]++;
    q.i_push = 0;
    q.i_pop = 0;
    status("cyc");
  endtask

  always @(negedge clk)
    if (!rst && q.i_pop && !q.o_empty_w[q.i_pop_ch]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected ch=%0d act=%0h exp=none", q.i_pop_ch, q.o_pop_dat);
      end else chk("pop_dat", 64'(q.o_pop_dat), 64'(exp_q.pop_front()));
    end

  initial begin
    q.i_push = 0;
    q.i_push_ch = 0;
    q.i_push_dat = 0;
    q.i_pop = 0;
    q.i_pop_ch = 0;
`ifdef QUEUE_RF_MC_ERR_EN
    q.i_err_clr = 0;
`endif
    for (int c = 0; c < C; c++) mc[c] = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_empty", 64'(q.o_empty_w), 64'hF);
    chk("reset_full", 64'(q.o_full_w), 64'h0);
    chk("reset_cnt", 64'(q.o_cnt_w), 64'h0);
    cyc(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2, W'('hA0 + i), 0, 0, 0);
    chk("ch2_full", 64'(q.o_full_w), 64'h4);
    cyc(1, 2, 'hAF, 0, 0, 0);
`ifdef QUEUE_RF_MC_ERR_EN
    chk("ch2_ovf", 64'(q.o_ovf_err), 64'h4);
`endif
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 2, W'('hA0 + i));
    chk("ch2_empty", 64'(q.o_empty_w), 64'hF);
    for (int i = 0; i < 4; i++) cyc(1, 1, W'('hB0 + i), 0, 0, 0);
    cyc(1, 1, 'h55, 1, 1, 'hB0);
    chk("ch1_cnt_full_pp", 64'(q.o_cnt_w[1*(A+1) +: A+1]), 64'd4);
    cyc(0, 0, 0, 1, 1, 'hB1);
    cyc(0, 0, 0, 1, 1, 'hB2);
    cyc(0, 0, 0, 1, 1, 'hB3);
    cyc(0, 0, 0, 1, 1, 'h55);
    cyc(1, 0, 'h11, 1, 0, 0);
    chk("ch0_cnt_empty_pp", 64'(q.o_cnt_w[0 +: A+1]), 64'd1);
`ifdef QUEUE_RF_MC_ERR_EN
    chk("ch0_udf", 64'(q.o_udf_err), 64'h1);
    q.i_err_clr = 1;
    @(posedge clk);
    #1 q.i_err_clr = 0;
    chk("err_clr", 64'({q.o_ovf_err, q.o_udf_err}), 64'h0);
`endif
    cyc(0, 0, 0, 1, 0, 'h11);
    for (int i = 0; i < 4; i++) r[i] = $urandom;
    for (int i = 0; i < 8; i++) rr[i] = (i == 0) ? 'h33 : $urandom;
    for (int i = 0; i < 4; i++) cyc(1, 1, r[i], 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 3, rr[i], 1, 1, (i < 4) ? r[i] : 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 3, rr[i]);
    chk("interleave_empty", 64'(q.o_empty_w), 64'hF);
    cyc(1, 0, 'hC0, 0, 0, 0);
    cyc(1, 0, 'hC1, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 0);
    q.i_push = 1;
    q.i_push_ch = 0;
    q.i_push_dat = 'hC2;
    q.i_pop = 1;
    q.i_pop_ch = 0;
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    q.i_push = 0;
    q.i_pop = 0;
    for (int c = 0; c < C; c++) mc[c] = 0;
    status("rst_mid");
`ifdef QUEUE_RF_MC_ERR_EN
    chk("rst_err", 64'({q.o_ovf_err, q.o_udf_err}), 64'h0);
`endif
    cyc(1, 0, 'hD0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 'hD0);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
